siso_frame_rx: RTL
==================

Name: siso_frame_rx

Overview:
- Downstream consumer of the 6-bit serial shift stage; samples its serial output `q` as `din`.
- Hunts the bit stream for a fixed sync word, then deserializes a fixed number of WIDTH-bit data words, MSB first.
- Presents each word on a parallel bus with a one-cycle valid strobe, then returns to hunting.
- Feeds parallel-domain logic (register file / display) that cannot consume a raw serial stream.

Parameters:
- WIDTH, 6, bits per word and per sync word.
- SYNC_WORD, 6'b101101, pattern that marks the start of a frame (WIDTH bits).
- NWORDS, 2, data words per frame after the sync word (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset: 0 = reset asserted.
- din  input  1  serial data bit from upstream shift stage.
- din_en  input  1  qualifies din; bit is sampled only on edges where din_en=1.
- dout  output  WIDTH  last completed data word, MSB = first received bit.
- dout_valid  output  1  one-cycle pulse: dout updated this cycle.
- frame_start  output  1  one-cycle pulse: sync word matched.
- frame_done  output  1  one-cycle pulse, coincident with dout_valid of the last word in a frame.
- locked  output  1  high while in the DATA (or PARITY) state.

Behaviour:
- Reset (reset=0, async): state=HUNT; hunt window, accumulator, bit_cnt, word_cnt cleared; dout=0; dout_valid, frame_start, frame_done and locked all 0.
- All outputs are registered. Pulses are high for exactly one clk cycle after the sampling edge.
- din_en=0: no state, counter or window changes; all pulses 0; dout holds.
- HUNT:
  - Each sampled bit shifts into a WIDTH-bit window: win <= {win[WIDTH-2:0], din}.
  - Match test is on the post-shift value: {win[WIDTH-2:0], din} == SYNC_WORD.
  - On match: next state DATA; bit_cnt=0; word_cnt=0; frame_start pulses.
  - Window is cleared on every entry to HUNT, so a sync match needs at least WIDTH fresh bits.
- DATA:
  - Sampled bits go into acc; bit_cnt increments on each sample.
  - When bit_cnt==WIDTH-1 and a bit is sampled: dout <= {acc[WIDTH-2:0], din}; dout_valid pulses; bit_cnt wraps to 0.
  - If word_cnt==NWORDS-1: frame_done pulses, next state HUNT, word_cnt=0, window cleared.
  - Otherwise word_cnt increments and the state stays DATA.
- Sync patterns appearing inside DATA are payload. No resync happens until the frame completes.
- locked = (state != HUNT), registered.
- Counter widths: bit_cnt is clog2(WIDTH) bits; word_cnt is clog2(NWORDS)+1 bits. No other arithmetic.
- Reset mid-frame: immediate return to HUNT. Partial words are discarded and never emitted.

Optional Feature:
- Macro: SISO_FRAME_RX_PARITY_EN.
- Defined:
  - Each data word is followed by one even-parity bit; state PARITY is entered after bit WIDTH-1.
  - dout and dout_valid (and frame_done) move to the edge that samples the parity bit.
  - Extra output port par_err (1 bit, reset 0) pulses with dout_valid when ^{word, parity_bit} != 0.
  - The word is still emitted when parity fails.
- Undefined: no PARITY state and no par_err port. Behaviour is exactly as above.

Decomposition:
- Shared package siso_pkg holds:
  - state enum HUNT/DATA/PARITY;
  - localparam defaults WORD_W=6 and SYNC_DEFAULT=6'b101101, shared with the shift stage and its bench.
- One natural sub-module, siso_sync_det: the WIDTH-bit hunt window plus comparator, with clear and shift-enable inputs and a match output.
- FSM, counters and the output registers stay in the top level.

Test Plan:
- Reset release, din_en=1, din=0 for 20 cycles -> locked=0, no pulses, dout=0.
- Stream 101101 then 110011, 000111 (NWORDS=2) -> frame_start one cycle after the 6th sync bit; dout=6'b110011 with dout_valid; then dout=6'b000111 with dout_valid and frame_done together; locked falls; state HUNT.
- Same stream with din_en low on alternate cycles -> identical output sequence; pulses stretched in time but each still exactly 1 cycle wide.
- Sync, then payload 101101, 010101 -> payload emitted as data (no frame_start mid-frame); next frame needs a fresh sync.
- Sync, 3 data bits, then reset low for 1 cycle, then a full valid frame -> no dout_valid for the partial word; the second frame is decoded correctly.
- With SISO_FRAME_RX_PARITY_EN: sync, 110011+parity 0, 000111+parity 0 -> first word par_err=0; second word par_err=1 (3 ones, even parity expects 1); both words still emitted.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared definitions for the 6-bit serial link: frame receiver state encoding
// and the default word width / sync pattern used by the shift stage and its benches.
package siso_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int         WORD_W       = 6;
  localparam logic [5:0] SYNC_DEFAULT = 6'b101101;

endpackage

// File: rtl/siso_sync_det.sv
// Sync-word hunter: WIDTH-bit shift window with a comparator on the post-shift
// value, so a match is flagged on the same edge that samples the last sync bit.
module siso_sync_det
  import siso_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(SYNC_DEFAULT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic shift,
  input  logic din,
  output logic match
);

  logic [WIDTH-1:0] win;
  logic [WIDTH-1:0] win_nxt;

  assign win_nxt = {win[WIDTH-2:0], din};
  assign match   = shift && (win_nxt == SYNC_WORD);

  // Clear wins over shift so a freshly re-entered hunt never sees stale payload bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win <= '0;
    end else if (clr) begin
      win <= '0;
    end else if (shift) begin
      win <= win_nxt;
    end
  end

endmodule

// File: rtl/siso_frame_rx.sv
// Serial frame receiver: hunts for SYNC_WORD, then deserializes NWORDS words MSB first.
// Optional SISO_FRAME_RX_PARITY_EN adds a trailing even-parity bit per word and a par_err pulse.
module siso_frame_rx
  import siso_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(SYNC_DEFAULT),
  parameter int               NWORDS    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             frame_done,
`ifdef SISO_FRAME_RX_PARITY_EN
  output logic             par_err,
`endif
  output logic             locked
);

  localparam int             BW        = $clog2(WIDTH);
  localparam int             CW        = $clog2(NWORDS) + 1;
  localparam logic [BW-1:0]  BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [CW-1:0]  WORD_LAST = CW'(NWORDS - 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    word_cnt;
  logic             match;
  logic             win_shift;
  logic             win_clr;
  logic             emit;
  logic [WIDTH-1:0] word;

  assign win_shift = din_en && (state == HUNT);

`ifdef SISO_FRAME_RX_PARITY_EN
  // The word is already complete in acc; this edge samples the parity bit.
  assign emit = din_en && (state == PARITY);
  assign word = acc;
`else
  assign emit = din_en && (state == DATA) && (bit_cnt == BIT_LAST);
  assign word = {acc[WIDTH-2:0], din};
`endif

  assign win_clr = emit && (word_cnt == WORD_LAST);

  siso_sync_det #(
    .WIDTH     (WIDTH),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_det (
    .clk   (clk),
    .reset (reset),
    .clr   (win_clr),
    .shift (win_shift),
    .din   (din),
    .match (match)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      acc         <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      locked      <= 1'b0;
`ifdef SISO_FRAME_RX_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
`ifdef SISO_FRAME_RX_PARITY_EN
      par_err     <= 1'b0;
`endif
      if (din_en) begin
        case (state)
          HUNT: begin
            if (match) begin
              state       <= DATA;
              locked      <= 1'b1;
              bit_cnt     <= '0;
              word_cnt    <= '0;
              frame_start <= 1'b1;
            end
          end
          DATA: begin
            acc <= {acc[WIDTH-2:0], din};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef SISO_FRAME_RX_PARITY_EN
              state   <= PARITY;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`ifdef SISO_FRAME_RX_PARITY_EN
          PARITY: state <= DATA;
`endif
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase

        // Word completion overrides the state chosen above when the frame ends.
        if (emit) begin
          dout       <= word;
          dout_valid <= 1'b1;
`ifdef SISO_FRAME_RX_PARITY_EN
          par_err    <= ^{acc, din};
`endif
          if (word_cnt == WORD_LAST) begin
            frame_done <= 1'b1;
            state      <= HUNT;
            locked     <= 1'b0;
            word_cnt   <= '0;
          end else begin
            word_cnt   <= word_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
